iseq_pair_loader: RTL and testbench
===================================

Name: iseq_pair_loader

Overview:
- Upstream feeder for the DDR instruction dispatcher.
- Accepts a host instruction stream (32-bit words, valid/ready, last marker) and distributes it round-robin into two slot FIFOs. Even-index words go to slot 0, odd-index words to slot 1.
- Once a full sequence is loaded, it presents both FIFO heads to the dispatcher's two instruction ports with an enable/ack handshake.
- Signals completion when both queues have drained.

Parameters:
- ADDR_WIDTH, 10, log2 of per-slot FIFO depth (depth = 2**ADDR_WIDTH).
- INSTR_WIDTH, 32, instruction word width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  host instruction word valid
- in_ready  output  1  loader can accept a word this cycle
- in_data  input  INSTR_WIDTH  host instruction word
- in_last  input  1  marks final word of the sequence
- en_in0  output  1  slot-0 head valid to dispatcher
- en_ack0  input  1  dispatcher consumed slot-0 head
- instr_in0  output  INSTR_WIDTH  slot-0 head word
- en_in1  output  1  slot-1 head valid
- en_ack1  input  1  dispatcher consumed slot-1 head
- instr_in1  output  INSTR_WIDTH  slot-1 head word
- busy  output  1  high while in EXEC
- seq_done  output  1  one-cycle pulse when sequence fully consumed
- overflow  output  1  sticky; a sequence exceeded FIFO capacity without in_last

Behaviour:
- Reset values:
  - State = LOAD; both FIFOs empty; slot pointer = 0.
  - in_ready=1, en_in0=en_in1=0, busy=0, seq_done=0, overflow=0.
  - instr_in0/1 don't-care.
  - Reset mid-operation discards all queued words.
- FSM states: LOAD, EXEC.
- LOAD:
  - in_ready = ~full[slot_ptr].
  - On in_valid & in_ready: write in_data to FIFO[slot_ptr], then toggle slot_ptr.
  - If in_last is also set: slot_ptr clears to 0, next state EXEC.
  - en_in0 = en_in1 = 0 throughout LOAD.
  - in_last on the very first word is legal; the sequence is slot0 only.
- Overflow:
  - If FIFO[slot_ptr] is full in LOAD and in_valid is high, in_ready=0 and overflow sets (sticky until rst).
  - Overflow also forces EXEC on the next cycle, so the stalled sequence is executed as loaded.
  - The stalled host word is not accepted.
- EXEC:
  - in_ready = 0; busy = 1.
  - en_inN = ~empty[N]; instr_inN = head of FIFO N, first-word-fall-through (valid in the same cycle en_inN is high).
  - Pop FIFO N when en_inN & en_ackN.
  - Acks on both slots in the same cycle pop both.
  - en_ackN while en_inN=0 is ignored; the dispatcher legitimately asserts ack with no enable.
- Completion:
  - When both FIFOs are empty at the end of a cycle in EXEC (including after the final pop), the next cycle pulses seq_done=1 for exactly one cycle and returns to LOAD.
  - busy falls in the same cycle seq_done is high.
  - An odd-length sequence leaves slot 1 empty earlier. en_in1 drops while en_in0 still presents, and done waits for both.
- Head update: after a pop, the next word appears on instr_inN in the following cycle with no bubble. Back-to-back pops at one per cycle per slot are sustained.
- Occupancy counters:
  - ADDR_WIDTH+1 bits per slot.
  - full = count == 2**ADDR_WIDTH; empty = count == 0.
  - Read/write pointers wrap modulo depth.
- Simultaneous events:
  - No push/pop overlap is possible, because pushes occur only in LOAD and pops only in EXEC.
  - in_valid during EXEC is not accepted and causes no state change.

Test Plan:
- Load 5 words A0..A4 (A4 with in_last), ack every cycle on both slots:
  - slot0 presents A0, A2, A4; slot1 presents A1, A3.
  - en_in1 drops after 2 pops.
  - seq_done pulses 1 cycle after A4 pops; in_ready returns to 1.
- Single word with in_last → EXEC, en_in0=1 with that word, en_in1=0; hold en_ack0=0 for 10 cycles → word stays presented; ack → seq_done pulse next cycle.
- ADDR_WIDTH=2, stream 9 words without in_last → 8 accepted, in_ready=0 on the 9th, overflow=1, EXEC entered, 4+4 words drained in order, overflow remains 1 after seq_done.
- In EXEC, assert en_ack0 with slot 0 empty and pulse in_valid → no pop, no accept, counts unchanged.
- Assert rst with 3 words pending in EXEC → en_in0=en_in1=0, busy=0, in_ready=1 next cycle. A fresh 2-word sequence then starts in slot 0.
- Fill a full depth-1024 sequence twice in succession → pointers wrap; second sequence order intact and seq_done pulses once per sequence.

Source files
------------

// File: rtl/iseq_pair_loader.sv
// Host instruction stream loader: splits a sequence round-robin into two slot
// FIFOs, then presents both heads to the dispatcher until both drain.
module iseq_pair_loader #(
   parameter int ADDR_WIDTH  = 10,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] in_data,
   input  logic                   in_last,
   output logic                   en_in0,
   input  logic                   en_ack0,
   output logic [INSTR_WIDTH-1:0] instr_in0,
   output logic                   en_in1,
   input  logic                   en_ack1,
   output logic [INSTR_WIDTH-1:0] instr_in1,
   output logic                   busy,
   output logic                   seq_done,
   output logic                   overflow
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic {LOAD, EXEC} state_t;

   state_t state_q, state_d;
   logic   slot_q, slot_d;
   logic   done_q, done_d;
   logic   ovf_q, ovf_d;

   logic [1:0][ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [1:0][ADDR_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [1:0]                 full, empty, push, pop;
   logic                       accept, loading;

   logic [INSTR_WIDTH-1:0] mem0 [DEPTH];
   logic [INSTR_WIDTH-1:0] mem1 [DEPTH];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         full[i]  = (cnt_q[i] == FULL_CNT);
         empty[i] = (cnt_q[i] == '0);
      end
   end

   assign loading   = (state_q == LOAD);
   assign in_ready  = loading & ~full[slot_q];
   assign accept    = in_ready & in_valid;
   assign push[0]   = accept & ~slot_q;
   assign push[1]   = accept & slot_q;
   assign en_in0    = ~loading & ~empty[0];
   assign en_in1    = ~loading & ~empty[1];
   assign pop[0]    = en_in0 & en_ack0;
   assign pop[1]    = en_in1 & en_ack1;
   assign instr_in0 = mem0[rd_q[0]];
   assign instr_in1 = mem1[rd_q[1]];
   assign busy      = ~loading;
   assign seq_done  = done_q;
   assign overflow  = ovf_q;

   // Pushes only happen in LOAD and pops only in EXEC, so one counter step per cycle.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = cnt_q[i];
         wr_d[i]  = wr_q[i];
         rd_d[i]  = rd_q[i];
         if (push[i]) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
            wr_d[i]  = wr_q[i] + 1'b1;
         end else if (pop[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
            rd_d[i]  = rd_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      case (state_q)
         LOAD: begin
            if (accept) begin
               slot_d = in_last ? 1'b0 : ~slot_q;
               if (in_last) state_d = EXEC;
            end else if (in_valid && full[slot_q]) begin
               // Capacity exhausted without in_last: run what was loaded.
               ovf_d   = 1'b1;
               slot_d  = 1'b0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_d[0] == '0 && cnt_d[1] == '0) begin
               done_d  = 1'b1;
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         slot_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push[0]) mem0[wr_q[0]] <= in_data;
      if (push[1]) mem1[wr_q[1]] <= in_data;
   end
endmodule

// File: tb/tb_iseq_pair_loader.sv
// Randomized bench for iseq_pair_loader: per-slot word queues model the
// expected dispatcher view; a small-depth instance exercises overflow.
module tb_iseq_pair_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_last, en_ack0, en_ack1;
   logic [31:0] in_data;
   logic        in_ready, en_in0, en_in1, busy, seq_done, overflow;
   logic [31:0] instr_in0, instr_in1;

   logic        s_in_valid, s_in_last, s_en_ack0, s_en_ack1;
   logic [31:0] s_in_data;
   logic        s_in_ready, s_en_in0, s_en_in1, s_busy, s_seq_done, s_overflow;
   logic [31:0] s_instr_in0, s_instr_in1;

   iseq_pair_loader #(.ADDR_WIDTH(10), .INSTR_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .en_in0(en_in0), .en_ack0(en_ack0),
      .instr_in0(instr_in0), .en_in1(en_in1), .en_ack1(en_ack1),
      .instr_in1(instr_in1), .busy(busy), .seq_done(seq_done), .overflow(overflow));

   iseq_pair_loader #(.ADDR_WIDTH(2), .INSTR_WIDTH(32)) dut_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .in_last(s_in_last), .en_in0(s_en_in0), .en_ack0(s_en_ack0),
      .instr_in0(s_instr_in0), .en_in1(s_en_in1), .en_ack1(s_en_ack1),
      .instr_in1(s_instr_in1), .busy(s_busy), .seq_done(s_seq_done), .overflow(s_overflow));

   logic [31:0] q0[$], q1[$];
   int checks = 0, errs = 0;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic load_seq(input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         logic [31:0] w;
         w = $urandom;
         if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            step();
         end
         checks++;
         if (in_ready !== 1'b1 || busy !== 1'b0 || en_in0 !== 1'b0 || en_in1 !== 1'b0) begin
            errs++;
            $display("FAIL load word %0d: in_ready=%b busy=%b en=%b%b, want 1 0 00",
                     i, in_ready, busy, en_in0, en_in1);
         end
         in_valid = 1'b1; in_data = w; in_last = with_last && (i == n - 1);
         step();
         if (i % 2 == 0) q0.push_back(w); else q1.push_back(w);
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // Random acks (including acks on empty slots) and ignored host traffic.
   task automatic drain(input int pct, input int hold, input int budget);
      int cyc = 0;
      bit a0, a1, fin = 0;
      while (!fin) begin
         checks++;
         if (busy !== 1'b1 || in_ready !== 1'b0 || seq_done !== 1'b0 ||
             en_in0 !== (q0.size() > 0) || en_in1 !== (q1.size() > 0)) begin
            errs++;
            $display("FAIL exec cyc %0d: busy=%b in_ready=%b done=%b en=%b%b, want 1 0 0 %b%b",
                     cyc, busy, in_ready, seq_done, en_in0, en_in1, q0.size() > 0, q1.size() > 0);
         end
         if (q0.size() > 0) begin
            checks++;
            if (instr_in0 !== q0[0]) begin
               errs++; $display("FAIL head0 cyc %0d: got %h want %h", cyc, instr_in0, q0[0]);
            end
         end
         if (q1.size() > 0) begin
            checks++;
            if (instr_in1 !== q1[0]) begin
               errs++; $display("FAIL head1 cyc %0d: got %h want %h", cyc, instr_in1, q1[0]);
            end
         end
         a0 = (cyc >= hold) && ($urandom_range(99) < pct);
         a1 = (cyc >= hold) && ($urandom_range(99) < pct);
         en_ack0 = a0; en_ack1 = a1;
         in_valid = 1'($urandom_range(1)); in_data = $urandom; in_last = 1'($urandom_range(1));
         step();
         if (a0 && q0.size() > 0) void'(q0.pop_front());
         if (a1 && q1.size() > 0) void'(q1.pop_front());
         cyc++;
         if (q0.size() == 0 && q1.size() == 0) fin = 1;
         else if (cyc > budget) begin
            errs++; $display("FAIL drain timeout: %0d/%0d words left", q0.size(), q1.size());
            fin = 1;
         end
      end
      en_ack0 = 1'b0; en_ack1 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      checks++;
      if (seq_done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || en_in0 !== 1'b0 || en_in1 !== 1'b0) begin
         errs++;
         $display("FAIL done pulse: done=%b busy=%b in_ready=%b en=%b%b, want 1 0 1 00",
                  seq_done, busy, in_ready, en_in0, en_in1);
      end
      step();
      checks++;
      if (seq_done !== 1'b0 || in_ready !== 1'b1) begin
         errs++; $display("FAIL done width: done=%b in_ready=%b, want 0 1", seq_done, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 0; in_last = 0; in_data = 0; en_ack0 = 0; en_ack1 = 0;
      s_in_valid = 0; s_in_last = 0; s_in_data = 0; s_en_ack0 = 0; s_en_ack1 = 0;
      step(); step();
      rst = 1'b0;
      step();
      checks++;
      if ({in_ready, en_in0, en_in1, busy, seq_done, overflow} !== 6'b100000 ||
          {s_in_ready, s_en_in0, s_en_in1, s_busy, s_seq_done, s_overflow} !== 6'b100000) begin
         errs++;
         $display("FAIL reset: main=%b small=%b, want 100000",
                  {in_ready, en_in0, en_in1, busy, seq_done, overflow},
                  {s_in_ready, s_en_in0, s_en_in1, s_busy, s_seq_done, s_overflow});
      end
   endtask

   task automatic test_odd_five();
      load_seq(5, 1);
      drain(100, 0, 20);
   endtask

   task automatic test_single_hold();
      load_seq(1, 1);
      drain(100, 10, 30);
   endtask

   task automatic test_exec_ignore();
      logic [31:0] h1;
      load_seq(4, 1);
      en_ack0 = 1'b1;
      step(); step();
      void'(q0.pop_front()); void'(q0.pop_front());
      h1 = q1[0];
      for (int i = 0; i < 3; i++) begin
         en_ack0 = 1'b1; en_ack1 = 1'b0; in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
         step();
         checks++;
         if (en_in0 !== 1'b0 || en_in1 !== 1'b1 || instr_in1 !== h1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL ignore %0d: en=%b%b head1=%h in_ready=%b busy=%b, want 01 %h 0 1",
                     i, en_in0, en_in1, instr_in1, in_ready, busy, h1);
         end
      end
      in_valid = 1'b0; en_ack0 = 1'b0;
      drain(70, 0, 100);
   endtask

   task automatic test_reset_mid();
      load_seq(3, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({in_ready, en_in0, en_in1, busy, seq_done} !== 5'b10000) begin
         errs++;
         $display("FAIL reset mid: ready/en0/en1/busy/done=%b, want 10000",
                  {in_ready, en_in0, en_in1, busy, seq_done});
      end
      q0.delete(); q1.delete();
      load_seq(2, 1);
      drain(100, 0, 20);
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         load_seq($urandom_range(1, 40), 1);
         drain(60, 0, 600);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 2; k++) begin
         load_seq(2048, 1);
         drain(100, 0, 2100);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errs++; $display("FAIL full seq overflow: got %b want 0", overflow);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] e0[$], e1[$];
      for (int i = 0; i < 9; i++) begin
         logic [31:0] w;
         w = $urandom;
         checks++;
         if (s_in_ready !== (i < 8)) begin
            errs++; $display("FAIL ovf ready word %0d: got %b want %b", i, s_in_ready, i < 8);
         end
         s_in_valid = 1'b1; s_in_data = w; s_in_last = 1'b0;
         step();
         if (i < 8) begin
            if (i % 2 == 0) e0.push_back(w); else e1.push_back(w);
         end
      end
      s_in_valid = 1'b0;
      checks++;
      if (s_overflow !== 1'b1 || s_busy !== 1'b1 || s_in_ready !== 1'b0) begin
         errs++; $display("FAIL ovf entry: ovf=%b busy=%b ready=%b, want 1 1 0", s_overflow, s_busy, s_in_ready);
      end
      s_en_ack0 = 1'b1; s_en_ack1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (s_en_in0 !== 1'b1 || s_en_in1 !== 1'b1 || s_instr_in0 !== e0[i] || s_instr_in1 !== e1[i]) begin
            errs++;
            $display("FAIL ovf drain %0d: en=%b%b heads=%h/%h want 11 %h/%h",
                     i, s_en_in0, s_en_in1, s_instr_in0, s_instr_in1, e0[i], e1[i]);
         end
         step();
      end
      s_en_ack0 = 1'b0; s_en_ack1 = 1'b0;
      checks++;
      if (s_seq_done !== 1'b1 || s_overflow !== 1'b1 || s_busy !== 1'b0) begin
         errs++; $display("FAIL ovf done: done=%b ovf=%b busy=%b, want 1 1 0", s_seq_done, s_overflow, s_busy);
      end
      step();
      checks++;
      if (s_seq_done !== 1'b0 || s_overflow !== 1'b1 || s_in_ready !== 1'b1) begin
         errs++; $display("FAIL ovf sticky: done=%b ovf=%b ready=%b, want 0 1 1", s_seq_done, s_overflow, s_in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_overflow();
      test_odd_five();
      test_single_hold();
      test_exec_ignore();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end
endmodule
